alu_multicycle_ex: RTL and testbench
====================================

Name: alu_multicycle_ex

Overview:
Execute-stage ALU that consumes the 5-bit ALU control code from the ID-stage ALU decoder, together with the two operands, and produces a registered result plus a branch decision. Logic, arithmetic, compare and branch ops complete in 1 cycle. Shifts (SLL/SRL/SRA) run iteratively, 1 bit per cycle, to avoid a barrel shifter. Valid/ready handshake on both sides, with flush support from the hazard unit.

Parameters:
XLEN, 32, operand/result width
SHAMT_W, 5, shift-amount width (log2 XLEN)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous, active-high reset
i_flush  input  1  synchronous kill of in-flight op and output register
i_valid  input  1  upstream op valid
o_ready  output  1  block can accept an op this cycle
i_alu_ctrl_EX  input  5  ALU control code (encoding below)
i_src_a  input  XLEN  operand A
i_src_b  input  XLEN  operand B; shift amount = i_src_b[SHAMT_W-1:0]
o_valid  output  1  result registers hold a valid result
i_ready  input  1  downstream accepts result
o_alu_result  output  XLEN  registered result
o_zero  output  1  registered (o_alu_result == 0)
o_branch_taken  output  1  registered branch condition; 0 for non-branch codes
o_illegal  output  1  registered; code not in table
o_busy  output  1  state == SHIFT

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous, active-high.
- Reset values: state=IDLE, o_valid=0, o_alu_result=0, o_zero=0, o_branch_taken=0, o_illegal=0, shift counter=0. Reset mid-shift aborts the shift; no result is produced.
- Codes:
  - 00000 AND, 00001 OR, 00010 XOR, 00011 ADD, 00100 SUB
  - 00101 SLL, 00110 SRL, 00111 SLT (signed), 01000 SLTU, 01001 SRA
  - 01010 BEQ, 01011 BNE, 01100 BLT, 01101 BLTU, 01110 BGE, 01111 BGEU
  - 10000-11111 illegal
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. SLT/SLTU result = {XLEN-1 zeros, cond}.
- Branch codes: o_alu_result = {zeros, taken} and o_branch_taken = taken. BGE/BGEU take on equality.
- Illegal codes: result=0, o_branch_taken=0, o_illegal=1.
- o_ready (combinational) = (state==IDLE) & (!o_valid | i_ready) & !i_flush.
- Accept occurs at an edge where i_valid & o_ready.
- States: IDLE, SHIFT.
  - IDLE, accept of a non-shift op, or a shift op with shamt==0: compute and register all outputs; o_valid=1 after that edge. Latency 1. Back-to-back accepts give 1 op/cycle.
  - IDLE, accept of a shift op with shamt=n>0: load work=i_src_a, cnt=n, latch op type; go to SHIFT.
  - SHIFT: each edge shifts work by 1 (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill) and decrements cnt.
  - SHIFT, edge where cnt==1: load the shifted value into o_alu_result, set o_valid=1, return to IDLE. Total latency n+1 edges from accept.
  - o_ready=0 throughout SHIFT; o_busy=1 throughout SHIFT.
- Output hold: while o_valid & !i_ready, all outputs stay stable. o_valid clears on an edge with i_ready=1 unless a new result is loaded on the same edge.
- Flush (highest priority after reset): on an edge with i_flush=1, o_valid→0, state→IDLE, cnt→0, and no accept occurs. Result data registers may hold stale values, but o_valid=0.
- No combinational path from i_src_*/i_alu_ctrl_EX to any output. o_ready depends only on state, o_valid, i_ready and i_flush.

Test Plan:
- ADD 5+7 (code 00011), i_ready=1 → o_valid 1 edge later, result=12, o_zero=0. SUB 3-5 (00100) on the next cycle → result=0xFFFFFFFE; throughput 1/cycle.
- SRA 0x80000000 by 4 (01001, src_b=4) → o_ready=0 and o_busy=1 for 4 cycles; o_valid after 5 edges; result=0xF8000000. SLL 0x1 by 0 → latency 1, result=0x1.
- BLT src_a=0xFFFFFFFF, src_b=1 (01100) → o_branch_taken=1, result=1. BGEU same operands (01111) → taken=1. BEQ 4,5 (01010) → taken=0, o_zero=1.
- Backpressure: result valid with i_ready=0 for 3 cycles → outputs stable, o_ready=0, new i_valid not accepted. Then i_ready=1 with i_valid=1 → old result retired and new op accepted on the same edge.
- Flush at cycle 2 of SRL 0xF0 by 8 → o_valid stays 0, o_ready=1 the cycle after the flush, next ADD completes normally. The same abort occurs with i_rst asserted mid-shift, leaving all outputs 0.
- Illegal code 10011 → o_illegal=1, result=0, o_branch_taken=0, latency 1. The next legal op clears o_illegal.

Source files
------------

// File: rtl/alu_multicycle_ex_if.sv
// rtl/alu_multicycle_ex_if.sv - handshake, operand and result bundle for the EX-stage ALU
interface alu_multicycle_ex_if #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
);
   logic            i_flush;
   logic            i_valid;
   logic            o_ready;
   logic [4:0]      i_alu_ctrl_EX;
   logic [XLEN-1:0] i_src_a;
   logic [XLEN-1:0] i_src_b;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_alu_result;
   logic            o_zero;
   logic            o_branch_taken;
   logic            o_illegal;
   logic            o_busy;

   modport slave (
      input  i_flush, i_valid, i_alu_ctrl_EX, i_src_a, i_src_b, i_ready,
      output o_ready, o_valid, o_alu_result, o_zero, o_branch_taken, o_illegal, o_busy
   );

   modport master (
      output i_flush, i_valid, i_alu_ctrl_EX, i_src_a, i_src_b, i_ready,
      input  o_ready, o_valid, o_alu_result, o_zero, o_branch_taken, o_illegal, o_busy
   );
endinterface

// File: rtl/alu_multicycle_ex.sv
// rtl/alu_multicycle_ex.sv - EX-stage ALU: single-cycle logic/arith/compare/branch, 1-bit-per-cycle shifts
module alu_multicycle_ex #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input logic               i_clk,
   input logic               i_rst,
   alu_multicycle_ex_if.slave bus
);
   localparam logic [4:0] OP_AND  = 5'd0,  OP_OR   = 5'd1,  OP_XOR  = 5'd2,  OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SLT  = 5'd7;
   localparam logic [4:0] OP_SLTU = 5'd8,  OP_SRA  = 5'd9,  OP_BEQ  = 5'd10, OP_BNE  = 5'd11;
   localparam logic [4:0] OP_BLT  = 5'd12, OP_BLTU = 5'd13, OP_BGE  = 5'd14, OP_BGEU = 5'd15;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state_q, state_d;
   logic [SHAMT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]     work_q, work_d;
   logic [4:0]          op_q, op_d;
   logic                valid_q, valid_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                zero_q, zero_d;
   logic                taken_q, taken_d;
   logic                illegal_q, illegal_d;

   logic [XLEN-1:0]     res_1c, shifted;
   logic                taken_1c, illegal_1c, is_shift, accept;
   logic [SHAMT_W-1:0]  shamt;

   assign shamt    = bus.i_src_b[SHAMT_W-1:0];
   assign is_shift = (bus.i_alu_ctrl_EX == OP_SLL) || (bus.i_alu_ctrl_EX == OP_SRL) ||
                     (bus.i_alu_ctrl_EX == OP_SRA);
   assign bus.o_ready = (state_q == IDLE) & (!valid_q | bus.i_ready) & !bus.i_flush;
   assign accept      = bus.i_valid & bus.o_ready;

   assign bus.o_valid        = valid_q;
   assign bus.o_alu_result   = result_q;
   assign bus.o_zero         = zero_q;
   assign bus.o_branch_taken = taken_q;
   assign bus.o_illegal      = illegal_q;
   assign bus.o_busy         = (state_q == SHIFT);

   // Shift codes only reach this path with shamt==0, so they pass operand A through.
   always_comb begin
      res_1c     = '0;
      taken_1c   = 1'b0;
      illegal_1c = 1'b0;
      case (bus.i_alu_ctrl_EX)
         OP_AND:  res_1c = bus.i_src_a & bus.i_src_b;
         OP_OR:   res_1c = bus.i_src_a | bus.i_src_b;
         OP_XOR:  res_1c = bus.i_src_a ^ bus.i_src_b;
         OP_ADD:  res_1c = bus.i_src_a + bus.i_src_b;
         OP_SUB:  res_1c = bus.i_src_a - bus.i_src_b;
         OP_SLL, OP_SRL, OP_SRA: res_1c = bus.i_src_a;
         OP_SLT:  res_1c = {{(XLEN-1){1'b0}}, $signed(bus.i_src_a) < $signed(bus.i_src_b)};
         OP_SLTU: res_1c = {{(XLEN-1){1'b0}}, bus.i_src_a < bus.i_src_b};
         OP_BEQ:  taken_1c = (bus.i_src_a == bus.i_src_b);
         OP_BNE:  taken_1c = (bus.i_src_a != bus.i_src_b);
         OP_BLT:  taken_1c = ($signed(bus.i_src_a) < $signed(bus.i_src_b));
         OP_BLTU: taken_1c = (bus.i_src_a < bus.i_src_b);
         OP_BGE:  taken_1c = ($signed(bus.i_src_a) >= $signed(bus.i_src_b));
         OP_BGEU: taken_1c = (bus.i_src_a >= bus.i_src_b);
         default: illegal_1c = 1'b1;
      endcase
      if (bus.i_alu_ctrl_EX[4:3] == 2'b01 && bus.i_alu_ctrl_EX[2:1] != 2'b00)
         res_1c = {{(XLEN-1){1'b0}}, taken_1c};
   end

   always_comb begin
      shifted = work_q;
      case (op_q)
         OP_SLL:  shifted = {work_q[XLEN-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, work_q[XLEN-1:1]};
         default: shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      op_d      = op_q;
      valid_d   = valid_q & !bus.i_ready;
      result_d  = result_q;
      zero_d    = zero_q;
      taken_d   = taken_q;
      illegal_d = illegal_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_shift && shamt != '0) begin
                  state_d = SHIFT;
                  cnt_d   = shamt;
                  work_d  = bus.i_src_a;
                  op_d    = bus.i_alu_ctrl_EX;
               end else begin
                  valid_d   = 1'b1;
                  result_d  = res_1c;
                  zero_d    = (res_1c == '0);
                  taken_d   = taken_1c;
                  illegal_d = illegal_1c;
               end
            end
         end
         SHIFT: begin
            work_d = shifted;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
               state_d   = IDLE;
               valid_d   = 1'b1;
               result_d  = shifted;
               zero_d    = (shifted == '0);
               taken_d   = 1'b0;
               illegal_d = 1'b0;
            end
         end
      endcase
      // Flush kills both the in-flight shift and the held result.
      if (bus.i_flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         op_q      <= '0;
         valid_q   <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         op_q      <= op_d;
         valid_q   <= valid_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         taken_q   <= taken_d;
         illegal_q <= illegal_d;
      end
   end
endmodule

// File: tb/tb_alu_multicycle_ex.sv
// tb/tb_alu_multicycle_ex.sv - vector table, hand sequences and random ops against a reference model
module tb_alu_multicycle_ex;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 i_clk = ~i_clk;

   alu_multicycle_ex_if #(.XLEN(32), .SHAMT_W(5)) bus ();

   alu_multicycle_ex #(.XLEN(32), .SHAMT_W(5)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   typedef struct {
      logic [4:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        tk;
      logic        il;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void ref_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic tk, output logic il,
                                     output int lat);
      int sh;
      sh  = int'(b[4:0]);
      r   = 0;
      tk  = 0;
      il  = 0;
      lat = 1;
      case (c)
         5'd0:  r = a & b;
         5'd1:  r = a | b;
         5'd2:  r = a ^ b;
         5'd3:  r = a + b;
         5'd4:  r = a - b;
         5'd5:  r = a << sh;
         5'd6:  r = a >> sh;
         5'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
         5'd8:  r = (a < b) ? 1 : 0;
         5'd9:  r = $signed(a) >>> sh;
         5'd10: tk = (a == b);
         5'd11: tk = (a != b);
         5'd12: tk = ($signed(a) < $signed(b));
         5'd13: tk = (a < b);
         5'd14: tk = ($signed(a) >= $signed(b));
         5'd15: tk = (a >= b);
         default: il = 1;
      endcase
      if (c >= 5'd10 && c <= 5'd15) r = tk ? 1 : 0;
      if ((c == 5'd5 || c == 5'd6 || c == 5'd9) && sh != 0) lat = sh + 1;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_op(input string name, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic etk,
                         input logic eil, input int elat);
      int n;
      int lat;
      n = 0;
      while (!bus.o_ready && n < 100) begin
         tick();
         n++;
      end
      bus.i_valid       = 1'b1;
      bus.i_alu_ctrl_EX = c;
      bus.i_src_a       = a;
      bus.i_src_b       = b;
      tick();
      bus.i_valid = 1'b0;
      lat = 1;
      while (!bus.o_valid && lat < 70) begin
         chk({name, " busy"}, 32'(bus.o_busy), 32'd1);
         chk({name, " ready_in_shift"}, 32'(bus.o_ready), 32'd0);
         tick();
         lat++;
      end
      chk({name, " latency"}, 32'(lat), 32'(elat));
      chk({name, " result"}, bus.o_alu_result, er);
      chk({name, " zero"}, 32'(bus.o_zero), 32'(er == 0));
      chk({name, " taken"}, 32'(bus.o_branch_taken), 32'(etk));
      chk({name, " illegal"}, 32'(bus.o_illegal), 32'(eil));
   endtask

   initial begin
      logic [4:0]  c;
      logic [31:0] a, b, r;
      logic        tk, il;
      int          lat;
      int          bad;

      vecs[0]  = '{5'b00011, 32'd5,        32'd7,        32'd12,         1'b0, 1'b0, 1};
      vecs[1]  = '{5'b00100, 32'd3,        32'd5,        32'hFFFF_FFFE,  1'b0, 1'b0, 1};
      vecs[2]  = '{5'b01001, 32'h8000_0000, 32'd4,       32'hF800_0000,  1'b0, 1'b0, 5};
      vecs[3]  = '{5'b00101, 32'd1,        32'd0,        32'd1,          1'b0, 1'b0, 1};
      vecs[4]  = '{5'b01100, 32'hFFFF_FFFF, 32'd1,       32'd1,          1'b1, 1'b0, 1};
      vecs[5]  = '{5'b01111, 32'hFFFF_FFFF, 32'd1,       32'd1,          1'b1, 1'b0, 1};
      vecs[6]  = '{5'b01010, 32'd4,        32'd5,        32'd0,          1'b0, 1'b0, 1};
      vecs[7]  = '{5'b10011, 32'd9,        32'd9,        32'd0,          1'b0, 1'b1, 1};
      vecs[8]  = '{5'b00011, 32'd1,        32'd1,        32'd2,          1'b0, 1'b0, 1};
      vecs[9]  = '{5'b00000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1};
      vecs[10] = '{5'b00001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1};
      vecs[11] = '{5'b00010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0, 1};
      vecs[12] = '{5'b01000, 32'd1,        32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 1};
      vecs[13] = '{5'b01110, 32'd7,        32'd7,        32'd1,          1'b1, 1'b0, 1};
      vecs[14] = '{5'b00110, 32'h0000_00F0, 32'd4,       32'h0000_000F,  1'b0, 1'b0, 5};
      vecs[15] = '{5'b00101, 32'd3,        32'd31,       32'h8000_0000,  1'b0, 1'b0, 32};

      bus.i_flush = 0; bus.i_valid = 0; bus.i_ready = 1;
      bus.i_alu_ctrl_EX = 0; bus.i_src_a = 0; bus.i_src_b = 0;
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;

      chk("rst valid", 32'(bus.o_valid), 0);
      chk("rst result", bus.o_alu_result, 0);
      chk("rst zero", 32'(bus.o_zero), 0);
      chk("rst taken", 32'(bus.o_branch_taken), 0);
      chk("rst illegal", 32'(bus.o_illegal), 0);
      chk("rst busy", 32'(bus.o_busy), 0);
      chk("rst ready", 32'(bus.o_ready), 1);

      for (int i = 0; i < 16; i++)
         run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].tk, vecs[i].il, vecs[i].lat);

      // Back-to-back single-cycle ops
      tick();
      bus.i_valid = 1; bus.i_alu_ctrl_EX = 5'b00011; bus.i_src_a = 5; bus.i_src_b = 7;
      tick();
      chk("b2b add valid", 32'(bus.o_valid), 1);
      chk("b2b add result", bus.o_alu_result, 12);
      chk("b2b ready", 32'(bus.o_ready), 1);
      bus.i_alu_ctrl_EX = 5'b00100; bus.i_src_a = 3; bus.i_src_b = 5;
      tick();
      bus.i_valid = 0;
      chk("b2b sub valid", 32'(bus.o_valid), 1);
      chk("b2b sub result", bus.o_alu_result, 32'hFFFF_FFFE);

      // Backpressure
      tick();
      bus.i_ready = 0;
      bus.i_valid = 1; bus.i_alu_ctrl_EX = 5'b00011; bus.i_src_a = 1; bus.i_src_b = 1;
      tick();
      chk("bp first result", bus.o_alu_result, 2);
      bus.i_alu_ctrl_EX = 5'b00010; bus.i_src_a = 32'hA5A5_0000; bus.i_src_b = 32'h0000_5A5A;
      for (int k = 0; k < 3; k++) begin
         chk("bp ready", 32'(bus.o_ready), 0);
         chk("bp valid", 32'(bus.o_valid), 1);
         chk("bp result", bus.o_alu_result, 2);
         tick();
      end
      bus.i_ready = 1;
      #1;
      chk("bp release ready", 32'(bus.o_ready), 1);
      tick();
      bus.i_valid = 0;
      chk("bp new valid", 32'(bus.o_valid), 1);
      chk("bp new result", bus.o_alu_result, 32'hA5A5_5A5A);

      // Flush during a shift
      bus.i_valid = 1; bus.i_alu_ctrl_EX = 5'b00110; bus.i_src_a = 32'hF0; bus.i_src_b = 8;
      tick();
      bus.i_valid = 0;
      tick();
      bus.i_flush = 1;
      #1;
      chk("flush ready low", 32'(bus.o_ready), 0);
      tick();
      bus.i_flush = 0;
      #1;
      chk("flush valid", 32'(bus.o_valid), 0);
      chk("flush ready", 32'(bus.o_ready), 1);
      chk("flush busy", 32'(bus.o_busy), 0);
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.o_valid) bad++;
      end
      chk("flush no late result", 32'(bad), 0);
      run_op("post flush add", 5'b00011, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1);

      // Reset during a shift
      bus.i_valid = 1; bus.i_alu_ctrl_EX = 5'b01001; bus.i_src_a = 32'hC000_0000; bus.i_src_b = 10;
      tick();
      bus.i_valid = 0;
      tick();
      tick();
      i_rst = 1;
      tick();
      i_rst = 0;
      chk("rst mid valid", 32'(bus.o_valid), 0);
      chk("rst mid result", bus.o_alu_result, 0);
      chk("rst mid taken", 32'(bus.o_branch_taken), 0);
      chk("rst mid illegal", 32'(bus.o_illegal), 0);
      chk("rst mid busy", 32'(bus.o_busy), 0);
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.o_valid) bad++;
      end
      chk("rst mid no late result", 32'(bad), 0);

      // Random ops against the reference model
      for (int i = 0; i < 250; i++) begin
         c = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         ref_model(c, a, b, r, tk, il, lat);
         run_op($sformatf("rand%0d code%0d", i, c), c, a, b, r, tk, il, lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
